// File: rtl/bram_share_arbiter_pkg.sv
// Shared types and constants for the two-requester BRAM sharing arbiter.
// Optional feature macro: BRAM_ARB_INIT_EN (power-up zero fill of the memory).
package bram_share_arbiter_pkg;

  // Number of agents sharing the memory.
  localparam int NUM_REQ = 2;

  // Default geometry, used by the request record below.
  localparam int PKG_ADDR_WIDTH = 10;
  localparam int PKG_COL_WIDTH  = 8;
  localparam int PKG_NB_COL     = 4;
  localparam int PKG_DW         = PKG_NB_COL * PKG_COL_WIDTH;

  // Controller state: INIT only exists when the zero fill is built in.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  // One request as presented by an agent (all-zero we means read).
  typedef struct packed {
    logic [PKG_NB_COL-1:0]     we;
    logic [PKG_ADDR_WIDTH-1:0] addr;
    logic [PKG_DW-1:0]         data;
  } req_t;

endpackage

// File: rtl/bram_bytewrite.sv
// Single-port, read-first block RAM with per-byte-lane write enables.
// Output register updates only on enabled cycles; contents are not reset.
module bram_bytewrite #(
  parameter int NB_COL     = 4,
  parameter int COL_WIDTH  = 8,
  parameter int SIZE       = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic [NB_COL-1:0]             we,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [NB_COL*COL_WIDTH-1:0]   din,
  output logic [NB_COL*COL_WIDTH-1:0]   dout
);

  logic [NB_COL*COL_WIDTH-1:0] mem [0:SIZE-1];

  // Read-first port: old word goes to dout, then enabled lanes are written.
  always_ff @(posedge clk) begin
    if (en) begin
      dout <= mem[addr];
      for (int i = 0; i < NB_COL; i++) begin
        if (we[i]) begin
          mem[addr][i*COL_WIDTH +: COL_WIDTH] <= din[i*COL_WIDTH +: COL_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/bram_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, pointer flips to the
// side that did not win after every grant.
module bram_rr_arb2
  import bram_share_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] elig,
  output logic [NUM_REQ-1:0] grant
);

  logic ptr_r;

  // Pick the single eligible side, or the pointer side when both contend.
  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_r ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer moves to the opposite side of whoever was just granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= 1'b0;
    end else if (grant[0]) begin
      ptr_r <= 1'b1;
    end else if (grant[1]) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/bram_share_arbiter_chk.sv
// Protocol checker for the arbiter: grant is one-hot-or-zero and only
// ever goes to a requester that is asking.
module bram_share_arbiter_chk
  import bram_share_arbiter_pkg::*;
(
  input logic               clk,
  input logic               reset_n,
  input logic [NUM_REQ-1:0] grant,
  input logic [NUM_REQ-1:0] req_v
);

  // A single port means a write and a read can never share a cycle.
  a_one_grant: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(grant));

  // Grants are only handed to valid requests.
  a_grant_valid: assert property (@(posedge clk) disable iff (!reset_n)
    (grant & ~req_v) == 2'b00);

endmodule

// File: rtl/bram_share_arbiter.sv
// Two-requester controller sharing one byte-write BRAM: round-robin grant,
// one outstanding read per requester, responses held until consumed.
// Optional feature macro: BRAM_ARB_INIT_EN (zero-fill INIT phase after reset).
module bram_share_arbiter
  import bram_share_arbiter_pkg::*;
#(
  parameter int SIZE       = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int COL_WIDTH  = 8,
  parameter int NB_COL     = 4
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [NUM_REQ-1:0]                      req_v_i,
  output logic [NUM_REQ-1:0]                      req_ready_o,
  input  logic [NUM_REQ*NB_COL-1:0]               req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]           req_addr_i,
  input  logic [NUM_REQ*NB_COL*COL_WIDTH-1:0]     req_data_i,
  output logic [NUM_REQ-1:0]                      resp_v_o,
  input  logic [NUM_REQ-1:0]                      resp_ready_i,
  output logic [NUM_REQ*NB_COL*COL_WIDTH-1:0]     resp_data_o,
  output logic                                    init_done_o
);

  localparam int DW = NB_COL * COL_WIDTH;

  logic                          serve_s;
  logic                          init_s;
  logic [ADDR_WIDTH-1:0]         init_addr_s;
  logic [NUM_REQ-1:0]            rd_s;
  logic [NUM_REQ-1:0]            resp_v_s;
  logic [NUM_REQ-1:0]            elig_s;
  logic [NUM_REQ-1:0]            grant_s;
  logic                          bram_en_s;
  logic [NB_COL-1:0]             bram_we_s;
  logic [ADDR_WIDTH-1:0]         bram_addr_s;
  logic [DW-1:0]                 bram_din_s;
  logic [DW-1:0]                 bram_dout_s;
  logic [NUM_REQ-1:0]            pending_r;
  logic [NUM_REQ-1:0]            held_r;
  logic [NUM_REQ-1:0][DW-1:0]    hold_data_r;

`ifdef BRAM_ARB_INIT_EN
  state_e                state_r;
  logic [ADDR_WIDTH-1:0] init_cnt_r;
  logic                  init_done_r;

  // Zero-fill sequencer: one word per cycle, then hand over to SERVE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= '0;
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (init_cnt_r == ADDR_WIDTH'(SIZE - 1)) begin
            state_r     <= ST_SERVE;
            init_done_r <= 1'b1;
          end else begin
            init_cnt_r  <= init_cnt_r + ADDR_WIDTH'(1);
          end
        end
        ST_SERVE: begin
          state_r     <= ST_SERVE;
          init_done_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_INIT;
          init_cnt_r  <= '0;
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign serve_s     = (state_r == ST_SERVE);
  assign init_s      = (state_r == ST_INIT);
  assign init_addr_s = init_cnt_r;
  assign init_done_o = init_done_r;
`else
  logic serve_r;

  // Holds off grants while reset is asserted; serving starts right after.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      serve_r <= 1'b0;
    end else begin
      serve_r <= 1'b1;
    end
  end

  assign serve_s     = serve_r;
  assign init_s      = 1'b0;
  assign init_addr_s = '0;
  assign init_done_o = 1'b1;
`endif

  // Eligibility: writes always, reads only when the response slot frees up.
  always_comb begin
    rd_s     = '0;
    resp_v_s = '0;
    elig_s   = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      rd_s[r]     = ~|req_we_i[r*NB_COL +: NB_COL];
      resp_v_s[r] = pending_r[r] | held_r[r];
      elig_s[r]   = serve_s & req_v_i[r] &
                    (~rd_s[r] | ~resp_v_s[r] | resp_ready_i[r]);
    end
  end

  bram_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .elig    (elig_s),
    .grant   (grant_s)
  );

  assign req_ready_o = grant_s;

  // BRAM port mux: fill pattern during INIT, else the granted request.
  always_comb begin
    bram_en_s   = 1'b0;
    bram_we_s   = '0;
    bram_addr_s = '0;
    bram_din_s  = '0;
    if (init_s) begin
      bram_en_s   = 1'b1;
      bram_we_s   = '1;
      bram_addr_s = init_addr_s;
      bram_din_s  = '0;
    end else if (grant_s[0]) begin
      bram_en_s   = 1'b1;
      bram_we_s   = req_we_i[0 +: NB_COL];
      bram_addr_s = req_addr_i[0 +: ADDR_WIDTH];
      bram_din_s  = req_data_i[0 +: DW];
    end else if (grant_s[1]) begin
      bram_en_s   = 1'b1;
      bram_we_s   = req_we_i[NB_COL +: NB_COL];
      bram_addr_s = req_addr_i[ADDR_WIDTH +: ADDR_WIDTH];
      bram_din_s  = req_data_i[DW +: DW];
    end else begin
      bram_en_s   = 1'b0;
      bram_we_s   = '0;
      bram_addr_s = '0;
      bram_din_s  = '0;
    end
  end

  bram_bytewrite #(
    .NB_COL     (NB_COL),
    .COL_WIDTH  (COL_WIDTH),
    .SIZE       (SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bram (
    .clk  (clk),
    .en   (bram_en_s),
    .we   (bram_we_s),
    .addr (bram_addr_s),
    .din  (bram_din_s),
    .dout (bram_dout_s)
  );

  // Response tracking: a read shows BRAM data the cycle after its grant and
  // is copied to the hold register if not consumed, so later traffic on the
  // shared BRAM output cannot disturb it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r   <= '0;
      held_r      <= '0;
      hold_data_r <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        pending_r[r] <= grant_s[r] & rd_s[r];
        if (held_r[r]) begin
          held_r[r] <= ~resp_ready_i[r];
        end else if (pending_r[r] && !resp_ready_i[r]) begin
          held_r[r]      <= 1'b1;
          hold_data_r[r] <= bram_dout_s;
        end else begin
          held_r[r] <= 1'b0;
        end
      end
    end
  end

  // Response data: held copy first, live BRAM output next, zero when idle.
  always_comb begin
    resp_data_o = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (held_r[r]) begin
        resp_data_o[r*DW +: DW] = hold_data_r[r];
      end else if (pending_r[r]) begin
        resp_data_o[r*DW +: DW] = bram_dout_s;
      end else begin
        resp_data_o[r*DW +: DW] = '0;
      end
    end
  end

  assign resp_v_o = resp_v_s;

  bram_share_arbiter_chk u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .grant   (grant_s),
    .req_v   (req_v_i)
  );

endmodule

// File: tb/tb_bram_share_arbiter.sv
// Self-checking bench for bram_share_arbiter (SIZE=16, 32-bit words).
// Builds with or without BRAM_ARB_INIT_EN.
module tb_bram_share_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_v_i;
  logic [1:0]  req_ready_o;
  logic [7:0]  req_we_i;
  logic [7:0]  req_addr_i;
  logic [63:0] req_data_i;
  logic [1:0]  resp_v_o;
  logic [1:0]  resp_ready_i;
  logic [63:0] resp_data_o;
  logic        init_done_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [31:0] model [16];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  we0;
    logic [3:0]  a0;
    logic [31:0] d0;
    logic [3:0]  we1;
    logic [3:0]  a1;
    logic [31:0] d1;
    logic [1:0]  rr;
    logic [1:0]  exp_rdy;
  } vec_t;

  vec_t tbl [15];

  bram_share_arbiter #(
    .SIZE       (16),
    .ADDR_WIDTH (4),
    .COL_WIDTH  (8),
    .NB_COL     (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_v_i      (req_v_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .resp_v_o     (resp_v_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .init_done_o  (init_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] v, input logic [3:0] we0, input logic [3:0] a0,
                       input logic [31:0] d0, input logic [3:0] we1, input logic [3:0] a1,
                       input logic [31:0] d1, input logic [1:0] rr);
    req_v_i      = v;
    req_we_i     = {we1, we0};
    req_addr_i   = {a1, a0};
    req_data_i   = {d1, d0};
    resp_ready_i = rr;
  endtask

  // Compare handshakes at the current (mid-cycle) time and update the scoreboard.
  task automatic sample(input logic [1:0] exp_ready);
    logic [31:0] got;
    logic [31:0] exp;
    logic [3:0]  we;
    logic [3:0]  a;
    logic [31:0] d;
    check("req_ready", 64'(req_ready_o), 64'(exp_ready));
    for (int r = 0; r < 2; r++) begin
      if (resp_v_o[r] && resp_ready_i[r]) begin
        got = resp_data_o[r*32 +: 32];
        if ((r == 0 && q0.size() == 0) || (r == 1 && q1.size() == 0)) begin
          check($sformatf("unexpected_resp%0d", r), 64'(1), 64'(0));
        end else begin
          exp = (r == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("resp_data%0d", r), 64'(got), 64'(exp));
        end
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (req_v_i[r] && req_ready_o[r]) begin
        we = req_we_i[r*4 +: 4];
        a  = req_addr_i[r*4 +: 4];
        d  = req_data_i[r*32 +: 32];
        if (we == 4'h0) begin
          if (r == 0) q0.push_back(model[a]);
          else        q1.push_back(model[a]);
        end else begin
          for (int l = 0; l < 4; l++) begin
            if (we[l]) model[a][l*8 +: 8] = d[l*8 +: 8];
          end
        end
      end
    end
  endtask

  task automatic step(input logic [1:0] exp_ready);
    @(negedge clk);
    sample(exp_ready);
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the memory to become usable, then one idle cycle.
  task automatic wait_init();
    int n = 0;
`ifdef BRAM_ARB_INIT_EN
    drive(2'b01, 4'hF, 4'd3, 32'h12345678, 4'h0, 4'd0, 32'h0, 2'b11);
    while (!init_done_o && n < 100) begin
      @(negedge clk);
      check("ready_in_init", 64'(req_ready_o), 64'(0));
      @(posedge clk);
      #1;
      n++;
    end
    check("init_cycles", 64'(n), 64'(16));
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
`else
    check("init_done_tied", 64'(init_done_o), 64'(1) + 64'(n));
`endif
    drive(2'b00, 4'h0, 4'd0, 32'h0, 4'h0, 4'd0, 32'h0, 2'b11);
    step(2'b00);
  endtask

  initial begin
    // req0 RMW on addr 3, req1 writes 7/1, req0 writes 2, contention on writes.
    tbl[0]  = '{2'b01, 4'hF, 4'd3, 32'hDEADBEEF, 4'h0, 4'd0,  32'h0,        2'b11, 2'b01};
    tbl[1]  = '{2'b01, 4'h2, 4'd3, 32'h0000AA00, 4'h0, 4'd0,  32'h0,        2'b11, 2'b01};
    tbl[2]  = '{2'b01, 4'h0, 4'd3, 32'h0,        4'h0, 4'd0,  32'h0,        2'b11, 2'b01};
    tbl[3]  = '{2'b10, 4'h0, 4'd0, 32'h0,        4'hF, 4'd7,  32'h11112222, 2'b11, 2'b10};
    tbl[4]  = '{2'b10, 4'h0, 4'd0, 32'h0,        4'hF, 4'd1,  32'h01010101, 2'b11, 2'b10};
    tbl[5]  = '{2'b01, 4'hF, 4'd2, 32'h02020202, 4'h0, 4'd0,  32'h0,        2'b11, 2'b01};
    tbl[6]  = '{2'b11, 4'hF, 4'd9, 32'hAAAA0009, 4'hF, 4'd10, 32'hBBBB000A, 2'b11, 2'b10};
    tbl[7]  = '{2'b11, 4'hF, 4'd9, 32'hAAAA0009, 4'hF, 4'd10, 32'hBBBB000A, 2'b11, 2'b01};
    // Both read every cycle: strict alternation.
    tbl[8]  = '{2'b11, 4'h0, 4'd1, 32'h0,        4'h0, 4'd2,  32'h0,        2'b11, 2'b10};
    tbl[9]  = '{2'b11, 4'h0, 4'd1, 32'h0,        4'h0, 4'd2,  32'h0,        2'b11, 2'b01};
    tbl[10] = '{2'b11, 4'h0, 4'd1, 32'h0,        4'h0, 4'd2,  32'h0,        2'b11, 2'b10};
    tbl[11] = '{2'b11, 4'h0, 4'd1, 32'h0,        4'h0, 4'd2,  32'h0,        2'b11, 2'b01};
    // Write 9 by req0 then read 9 by req1 the next cycle.
    tbl[12] = '{2'b01, 4'hF, 4'd9, 32'h99999999, 4'h0, 4'd0,  32'h0,        2'b11, 2'b01};
    tbl[13] = '{2'b10, 4'h0, 4'd0, 32'h0,        4'h0, 4'd9,  32'h0,        2'b11, 2'b10};
    tbl[14] = '{2'b00, 4'h0, 4'd0, 32'h0,        4'h0, 4'd0,  32'h0,        2'b11, 2'b00};

    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    // Reset state, with requests already pending.
    reset_n = 1'b0;
    drive(2'b11, 4'h0, 4'd1, 32'h0, 4'h0, 4'd2, 32'h0, 2'b11);
    #12;
    check("rst_ready", 64'(req_ready_o), 64'(0));
    check("rst_resp_v", 64'(resp_v_o), 64'(0));
    check("rst_resp_data", resp_data_o, 64'(0));
`ifdef BRAM_ARB_INIT_EN
    check("rst_init_done", 64'(init_done_o), 64'(0));
`else
    check("rst_init_done", 64'(init_done_o), 64'(1));
`endif
    @(posedge clk);
    #1;
    drive(2'b00, 4'h0, 4'd0, 32'h0, 4'h0, 4'd0, 32'h0, 2'b11);
    reset_n = 1'b1;
    wait_init();

`ifdef BRAM_ARB_INIT_EN
    // Zero-filled word read back by req1 (pointer stays at 0).
    drive(2'b10, 4'h0, 4'd0, 32'h0, 4'h0, 4'd5, 32'h0, 2'b11);
    step(2'b10);
`endif

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].we0, tbl[i].a0, tbl[i].d0,
            tbl[i].we1, tbl[i].a1, tbl[i].d1, tbl[i].rr);
      step(tbl[i].exp_rdy);
    end

    // Held response: req1 reads 7 and stalls while req0 rewrites 7.
    drive(2'b10, 4'h0, 4'd0, 32'h0, 4'h0, 4'd7, 32'h0, 2'b01);
    step(2'b10);
    drive(2'b11, 4'hF, 4'd7, 32'h33334444, 4'h0, 4'd7, 32'h0, 2'b01);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_v1", 64'(resp_v_o[1]), 64'(1));
      check("hold_data1", 64'(resp_data_o[63:32]), 64'h11112222);
      sample(2'b01);
      @(posedge clk);
      #1;
    end
    drive(2'b10, 4'h0, 4'd0, 32'h0, 4'h0, 4'd7, 32'h0, 2'b11);
    step(2'b10);
    drive(2'b00, 4'h0, 4'd0, 32'h0, 4'h0, 4'd0, 32'h0, 2'b10);
    step(2'b00);

    // Reset while a read response is pending.
    drive(2'b01, 4'h0, 4'd1, 32'h0, 4'h0, 4'd0, 32'h0, 2'b00);
    step(2'b01);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_resp_v", 64'(resp_v_o), 64'(0));
    check("midrst_resp_data", resp_data_o, 64'(0));
    check("midrst_ready", 64'(req_ready_o), 64'(0));
    q0.delete();
    q1.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    drive(2'b00, 4'h0, 4'd0, 32'h0, 4'h0, 4'd0, 32'h0, 2'b11);
    reset_n = 1'b1;
    wait_init();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_stale_resp", 64'(resp_v_o), 64'(0));
      sample(2'b00);
      @(posedge clk);
      #1;
    end

    check("q0_drained", 64'(q0.size()), 64'(0));
    check("q1_drained", 64'(q1.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
